// File: rtl/tff_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the TFF cell command sequencer.
package tff_ctrl_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_CLR  = 3'd2,
    ST_WR   = 3'd3,
    ST_RD   = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

endpackage

// File: rtl/tff_sync.sv
// Multi-flop synchronizer bringing the asynchronous TFF cell outputs into clk.
module tff_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/tff_ctrl.sv
// Command sequencer driving WE/RE/rstb strobes of a TFF cell bank.
// Define TFF_CTRL_AUTOCLEAR_EN to insert a one-cycle cell clear before every WRITE.
module tff_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int NCELLS      = 4,
  parameter int AW          = 2,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DW-1:0]     cmd_dur,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic [NCELLS-1:0] tff_we,
  output logic [NCELLS-1:0] tff_re,
  output logic [NCELLS-1:0] tff_rstb,
  input  logic [NCELLS-1:0] tff_out,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: a command transfers on a clk edge where cmd_valid && cmd_ready,
  // a response transfers on an edge where rsp_valid && rsp_ready; a raised
  // valid holds its payload stable until that transfer.

  localparam logic [DW-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d, addr_sel;
  logic [DW-1:0]     dur_q, dur_d, cnt_q, cnt_d, rsp_data_q, rsp_data_d;
  logic              ref_q, ref_d, rsp_err_q, rsp_err_d;
  logic [NCELLS-1:0] we_q, we_d, re_q, re_d, rstb_q, rstb_d;
  logic [NCELLS-1:0] tff_out_s, cell_mask;
  logic              cell_s, cmd_bad;

  tff_sync #(.W(NCELLS), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d_i  (tff_out),
    .q_o  (tff_out_s)
  );

  // In IDLE the target comes straight from the command so strobes launch on the accept edge.
  assign addr_sel  = (state_q == ST_IDLE) ? cmd_addr : addr_q;
  assign cell_s    = tff_out_s[addr_sel];
  assign cell_mask = NCELLS'(1) << addr_sel;
  assign cmd_bad   = (int'(cmd_addr) >= NCELLS) || (cmd_op == OP_RSVD);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    dur_d      = dur_q;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          dur_d      = cmd_dur;
          cnt_d      = DW'(1);
          ref_d      = cell_s;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (cmd_bad) begin
            state_d   = ST_RSP;
            rsp_err_d = 1'b1;
          end else begin
            case (cmd_op)
              OP_CLEAR: state_d = ST_CLR;
              OP_WRITE: begin
                rsp_data_d = cmd_dur;
`ifdef TFF_CTRL_AUTOCLEAR_EN
                state_d = ST_CLR;
`else
                state_d = (cmd_dur == '0) ? ST_RSP : ST_WR;
`endif
              end
              default: state_d = ST_RD;
            endcase
          end
        end
      end
      ST_CLR: state_d = (op_q == OP_WRITE && dur_q != '0) ? ST_WR : ST_RSP;
      ST_WR: begin
        if (cnt_q == dur_q) state_d = ST_RSP;
        else                cnt_d   = cnt_q + DW'(1);
      end
      ST_RD: begin
        // A toggle on the final count still reports as a valid measurement.
        if (cell_s != ref_q) begin
          state_d    = ST_RSP;
          rsp_data_d = cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = ST_RSP;
          rsp_data_d = CNT_MAX;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      ST_RSP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    we_d   = (state_d == ST_WR)  ? cell_mask  : '0;
    re_d   = (state_d == ST_RD)  ? cell_mask  : '0;
    rstb_d = (state_d == ST_CLR) ? ~cell_mask : '1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_INIT;
      op_q       <= OP_CLEAR;
      addr_q     <= '0;
      dur_q      <= '0;
      cnt_q      <= '0;
      ref_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      we_q       <= '0;
      re_q       <= '0;
      rstb_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      dur_q      <= dur_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rstb_q     <= rstb_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RSP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign tff_we      = we_q;
  assign tff_re      = re_q;
  assign tff_rstb    = rstb_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tff_ctrl.sv
// Scoreboard bench for tff_ctrl: directed scenarios plus randomized commands.
module tb_tff_ctrl;

  localparam int NCELLS = 4;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int SYNC_STAGES = 2;
  localparam int W = 46;
`ifdef TFF_CTRL_AUTOCLEAR_EN
  localparam int AC = 1;
`else
  localparam int AC = 0;
`endif

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              rsp_ready = 1'b0;
  logic [1:0]        cmd_op = '0;
  logic [AW-1:0]     cmd_addr = '0;
  logic [DW-1:0]     cmd_dur = '0;
  logic [NCELLS-1:0] tff_out = '0;
  logic              cmd_ready, rsp_valid, rsp_err;
  logic [DW-1:0]     rsp_data;
  logic [NCELLS-1:0] tff_we, tff_re, tff_rstb;
  logic [2:0]        dbg_state;

  tff_ctrl #(.NCELLS(NCELLS), .AW(AW), .DW(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_dur     (cmd_dur),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .tff_we      (tff_we),
    .tff_re      (tff_re),
    .tff_rstb    (tff_rstb),
    .tff_out     (tff_out),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: {err, data, we cycles, re cycles, clear cycles, latency to rsp_valid}
  function automatic logic [W-1:0] model(input int op, input int addr, input int dur, input int k);
    int err = 0, data = 0, we = 0, re = 0, clr = 0, lat = 1;
    if (op == 3 || addr >= NCELLS) begin
      err = 1;
    end else if (op == 0) begin
      clr = 1; lat = 2;
    end else if (op == 1) begin
      data = dur; we = dur; clr = AC; lat = dur + 1 + AC;
    end else if (k > 0 && k + SYNC_STAGES <= 255) begin
      data = k + SYNC_STAGES; re = data; lat = data + 1;
    end else begin
      err = 1; data = 255; re = 255; lat = 256;
    end
    return {1'(err), 8'(data), 9'(we), 9'(re), 9'(clr), 10'(lat)};
  endfunction

  // ---------------- response ready generator ----------------
  bit hold_rsp = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  int ncyc = 0, acc_cyc = 0, done_cnt = 0;
  int we_cnt = 0, re_cnt = 0, clr_cnt = 0, bad_cnt = 0;
  bit in_rsp = 1'b0, mon_en = 1'b0;
  logic [NCELLS-1:0] cur_mask = '0;
  logic [W-1:0] e;

  always @(negedge clk) begin
    ncyc++;
    if (!rstb || !mon_en) begin
      in_rsp = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = ncyc;
        we_cnt = 0; re_cnt = 0; clr_cnt = 0; bad_cnt = 0;
        cur_mask = NCELLS'(1) << cmd_addr;
      end
      if (tff_we == cur_mask) we_cnt++;
      else if (tff_we != '0) bad_cnt++;
      if (tff_re == cur_mask) re_cnt++;
      else if (tff_re != '0) bad_cnt++;
      if (tff_rstb == ~cur_mask) clr_cnt++;
      else if (tff_rstb != '1) bad_cnt++;
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          chk("rsp_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("rsp_latency", ncyc - acc_cyc, e[9:0]);
            chk("rsp_data_first", rsp_data, e[44:37]);
          end
        end
        if (rsp_ready) begin
          in_rsp = 1'b0;
          done_cnt++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e[44:37]);
            chk("rsp_err", rsp_err, e[45]);
            chk("we_cycles", we_cnt, e[36:28]);
            chk("re_cycles", re_cnt, e[27:19]);
            chk("clr_cycles", clr_cnt, e[18:10]);
            chk("stray_strobes", bad_cnt, 0);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int op, input int addr, input int dur, input int k,
                      input bit expect_rsp, input bit wait_done);
    int b = 0;
    int d0;
    d0 = done_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_addr  = AW'(addr);
    cmd_dur   = DW'(dur);
    while (!cmd_ready && b < 1000) begin
      @(posedge clk); #1; b++;
    end
    chk("cmd_accept", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    if (expect_rsp) exp_q.push_back(model(op, addr, dur, k));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (op == 2 && k > 0) begin
      repeat (k - 1) @(posedge clk);
      #1;
      tff_out[addr] = ~tff_out[addr];
    end
    if (wait_done) begin
      b = 0;
      while (done_cnt == d0 && b < 2000) begin
        @(posedge clk); #1; b++;
      end
      chk("rsp_done", done_cnt != d0, 1);
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rstb = 1'b1;
    chk("init_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("release_tff_rstb", tff_rstb, 4'b1111);
    chk("release_cmd_ready", cmd_ready, 1);
    mon_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int b;
    int d0;
    int vcnt;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_tff_rstb", tff_rstb, 4'b0000);
    chk("rst_tff_we", tff_we, 0);
    chk("rst_tff_re", tff_re, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    release_reset();

    send(1, 2, 5, 0, 1, 1);   // WRITE addr 2, dur 5
    send(2, 1, 0, 7, 1, 1);   // READ addr 1, toggle after RE cycle 7
    send(2, 0, 0, 0, 1, 1);   // READ addr 0, timeout
    send(0, 3, 0, 0, 1, 1);   // CLEAR addr 3
    send(3, 1, 9, 0, 1, 1);   // reserved opcode
    send(1, 0, 0, 0, 1, 1);   // WRITE dur 0
    send(1, 3, 1, 0, 1, 1);   // WRITE dur 1
    send(2, 2, 0, 1, 1, 1);   // READ, earliest toggle
    send(1, 1, 255, 0, 1, 1); // WRITE max duration

    // Backpressure: response must hold while rsp_ready stays low.
    hold_rsp = 1'b1;
    d0 = done_cnt;
    send(1, 3, 4, 0, 1, 0);
    b = 0;
    while (!rsp_valid && b < 100) begin
      @(posedge clk); #1; b++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_data_held", rsp_data, 4);
      chk("bp_err_held", rsp_err, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    hold_rsp = 1'b0;
    b = 0;
    while (done_cnt == d0 && b < 100) begin
      @(posedge clk); #1; b++;
    end
    chk("bp_done", done_cnt != d0, 1);

    // Reset abort on WR cycle 3 of 5.
    send(1, 1, 5, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_we_active", tff_we, 4'b0010);
    mon_en = 1'b0;
    rstb = 1'b0;
    #1;
    chk("abort_we", tff_we, 0);
    chk("abort_tff_rstb", tff_rstb, 4'b0000);
    chk("abort_cmd_ready", cmd_ready, 0);
    repeat (3) @(posedge clk);
    release_reset();
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) vcnt++;
    end
    chk("abort_no_rsp", vcnt, 0);

    for (int i = 0; i < 40; i++) begin
      int op, addr, dur, k;
      op   = $urandom_range(0, 3);
      addr = $urandom_range(0, 3);
      dur  = $urandom_range(0, 20);
      k    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      send(op, addr, dur, k, 1'b1, 1'b1);
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
